// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//
// Memory-stage load/store unit. Takes the EX/MEM pipeline register outputs,
// drives a valid/grant data-memory port, lane-aligns store data, extracts and
// sign/zero-extends load data, and owns the MEM/WB pipeline register.
// Upstream stages are held through StallM while an access is outstanding.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed waiting for dmem_gnt / dmem_rvalid (1..65535)
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   ValidM, MemReadM, MemWriteM   M-stage slot valid, load, store
//   Funct3M                       access size / signedness
//   RegWriteM, ResultSrcM         write-back controls, passed through
//   ALUResultM, RD2M, PCPlus4M    address / ALU result, store data, PC+4
//   rdM                           destination register
//   dmem_req/we/addr/be/wdata     data-memory request channel
//   dmem_gnt                      request accepted this cycle
//   dmem_rvalid, dmem_rdata       read response
//   StallM                        hold IF/ID/EX/MEM registers
//   MemErrM                       one-cycle pulse: misaligned, illegal, timeout
//   RegWriteW .. rdW              MEM/WB pipeline register outputs
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ValidM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] RD2M,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  rdM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        MemErrM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  rdW
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Last counter value before the wait is abandoned: the counter reads 0 on
    // the first waiting cycle, so TIMEOUT_CYCLES waiting cycles end at N-1.
    localparam logic [15:0] L_TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    state_t      r_state;
    logic [15:0] r_cnt;

    logic w_memop;
    logic w_misalign;
    logic w_illegal;
    logic w_bad;
    logic w_tmo_hit;
    logic w_req;
    logic w_stall;
    logic w_err;
    logic w_load_done;

    // Selects the byte or halfword lane and applies sign or zero extension.
    function automatic logic [31:0] load_extend(
        input logic [2:0]  f3,
        input logic [1:0]  a,
        input logic [31:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'd0, b};
            3'b101:  load_extend = {16'd0, h};
            default: load_extend = w;
        endcase
    endfunction

    assign w_memop   = ValidM & (MemReadM | MemWriteM);
    assign w_bad     = w_misalign | w_illegal | (MemReadM & MemWriteM);
    assign w_tmo_hit = (r_cnt == L_TMO_LAST);

    // Access legality: alignment per size and Funct3M encodings valid for the op.
    always_comb begin
        w_misalign = 1'b0;
        w_illegal  = 1'b0;
        case (Funct3M)
            3'b000: begin
                w_misalign = 1'b0;
                w_illegal  = 1'b0;
            end
            3'b001:  w_misalign = ALUResultM[0];
            3'b010:  w_misalign = |ALUResultM[1:0];
            3'b100:  w_illegal  = MemWriteM;
            3'b101: begin
                w_misalign = ALUResultM[0];
                w_illegal  = MemWriteM;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Store lane placement; addr/be/wdata follow the held M inputs, so they
    // stay stable for as long as the request is stalled.
    always_comb begin
        dmem_addr = {ALUResultM[31:2], 2'b00};
        case (Funct3M[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << ALUResultM[1:0];
                dmem_wdata = {4{RD2M[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << {ALUResultM[1], 1'b0};
                dmem_wdata = {2{RD2M[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = RD2M;
            end
        endcase
    end

    // Per-state request, stall, error and load-completion decisions.
    always_comb begin
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_err       = 1'b0;
        w_load_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_memop) begin
                    if (w_bad) begin
                        w_err = 1'b1;
                    end else begin
                        w_req   = 1'b1;
                        w_stall = ~(dmem_gnt & MemWriteM);
                    end
                end else begin
                    w_req = 1'b0;
                end
            end
            ST_REQ: begin
                w_req = 1'b1;
                if (dmem_gnt) begin
                    w_stall = ~MemWriteM;
                end else if (w_tmo_hit) begin
                    w_err = 1'b1;
                end else begin
                    w_stall = 1'b1;
                end
            end
            ST_RESP: begin
                if (dmem_rvalid) begin
                    w_load_done = 1'b1;
                end else if (w_tmo_hit) begin
                    w_err = 1'b1;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: begin
                w_req = 1'b0;
            end
        endcase
    end

    // Reset gates the handshake outputs so the request drops without waiting
    // for a clock edge, even if the M inputs still describe an access.
    assign dmem_req = w_req & ~rst;
    assign dmem_we  = w_req & MemWriteM & ~rst;
    assign StallM   = w_stall & ~rst;
    assign MemErrM  = w_err & ~rst;

    // Access FSM and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_memop & ~w_bad & ~dmem_gnt) begin
                        r_state <= ST_REQ;
                        r_cnt   <= 16'd0;
                    end else if (w_memop & ~w_bad & MemReadM) begin
                        r_state <= ST_RESP;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt) begin
                        r_state <= MemReadM ? ST_RESP : ST_IDLE;
                        r_cnt   <= 16'd0;
                    end else if (w_tmo_hit) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    if (dmem_rvalid | w_tmo_hit) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

    // MEM/WB register: bubble (RegWriteW=0, rest held) while stalled; an
    // erroring access still retires but never writes the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'd0;
            ALUResultW <= 32'd0;
            ReadDataW  <= 32'd0;
            PCPlus4W   <= 32'd0;
            rdW        <= 5'd0;
        end else if (w_stall) begin
            RegWriteW <= 1'b0;
        end else begin
            RegWriteW  <= ValidM & RegWriteM & ~w_err;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= w_load_done ? load_extend(Funct3M, ALUResultM[1:0], dmem_rdata) : 32'd0;
            PCPlus4W   <= PCPlus4M;
            rdW        <= rdM;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        ValidM, MemReadM, MemWriteM, RegWriteM;
    logic [2:0]  Funct3M;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, RD2M, PCPlus4M;
    logic [4:0]  rdM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        StallM, MemErrM, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  rdW;

    int checks;
    int failures;

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .ValidM(ValidM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .RD2M(RD2M), .PCPlus4M(PCPlus4M), .rdM(rdM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .MemErrM(MemErrM), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .PCPlus4W(PCPlus4W), .rdW(rdW)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (arithmetic on the access rules) -------
    function automatic int m_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        else if (f3 == 3'd1 || f3 == 3'd5) return 2;
        else return 4;
    endfunction

    function automatic bit m_bad(input logic [2:0] f3, input bit rd, input bit wr, input logic [31:0] addr);
        if (rd && wr) return 1'b1;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (wr && f3 >= 3'd4) return 1'b1;
        return (int'(addr % 32'd4) % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz, off;
        sz  = m_size(f3);
        off = int'(addr % 32'd4) / sz * sz;
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz;
        sz = m_size(f3);
        if (sz == 1) return (d & 32'h0000_00FF) * 32'h0101_0101;
        else if (sz == 2) return (d & 32'h0000_FFFF) * 32'h0001_0001;
        else return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] w);
        longint v;
        int sz, off;
        sz  = m_size(f3);
        off = int'(addr % 32'd4) / sz * sz;
        v = (longint'(w) >> (8 * off)) & ((longint'(1) << (8 * sz)) - 1);
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    task automatic idle_inputs();
        ValidM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'd0;
        RegWriteM = 1'b0; ResultSrcM = 2'd0; ALUResultM = 32'd0; RD2M = 32'd0;
        PCPlus4M = 32'd0; rdM = 5'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    endtask

    // ---------------- tests --------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        ValidM = 1'b1; MemReadM = 1'b1; Funct3M = 3'd2; ALUResultM = 32'h100;
        #1;
        checks++;
        if ({dmem_req, StallM, MemErrM} !== 3'b000) begin
            failures++; $display("FAIL reset_ctrl: got req/stall/err=%b required 000", {dmem_req, StallM, MemErrM});
        end
        checks++;
        if ({RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, rdW} !== 104'd0) begin
            failures++; $display("FAIL reset_w: got alu=%h rd=%h pc=%h required zeros", ALUResultW, ReadDataW, PCPlus4W);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu(input int n);
        logic [31:0] alu, pc;
        logic [4:0]  rd;
        logic [1:0]  rs;
        logic        rw;
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin alu = 32'h1234; rd = 5'd5; rw = 1'b1; pc = 32'h8; rs = 2'd0; end
            else begin alu = $urandom; rd = 5'($urandom); rw = 1'($urandom); pc = $urandom; rs = 2'($urandom); end
            @(negedge clk);
            ValidM = 1'b1; RegWriteM = rw; ALUResultM = alu; rdM = rd; PCPlus4M = pc; ResultSrcM = rs;
            Funct3M = 3'($urandom); RD2M = $urandom;
            #1;
            checks++;
            if ({dmem_req, StallM, MemErrM} !== 3'b000) begin
                failures++; $display("FAIL alu_ctrl: got req/stall/err=%b required 000", {dmem_req, StallM, MemErrM});
            end
            @(negedge clk);
            checks++;
            if ({RegWriteW, rdW, ALUResultW, PCPlus4W, ResultSrcW, ReadDataW} !== {rw, rd, alu, pc, rs, 32'd0}) begin
                failures++;
                $display("FAIL alu_w: got rw=%b rd=%0d alu=%h pc=%h rs=%0d rdata=%h required rw=%b rd=%0d alu=%h pc=%h rs=%0d rdata=0",
                         RegWriteW, rdW, ALUResultW, PCPlus4W, ResultSrcW, ReadDataW, rw, rd, alu, pc, rs);
            end
            idle_inputs();
        end
    endtask

    task automatic test_store(input int n);
        logic [2:0]  f3;
        logic [31:0] addr, d, pc;
        logic [4:0]  rd;
        logic        rw;
        int          g;
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin f3 = 3'd0; addr = 32'h1003; d = 32'hAB; g = 0; end
            else begin
                f3 = 3'($urandom_range(0, 2));
                addr = $urandom & ~32'(m_size(f3) - 1);
                d = $urandom; g = $urandom_range(0, 3);
            end
            rw = 1'($urandom); rd = 5'($urandom); pc = $urandom;
            for (int c = 0; c <= g; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    ValidM = 1'b1; MemWriteM = 1'b1; MemReadM = 1'b0; Funct3M = f3; RegWriteM = rw;
                    ALUResultM = addr; RD2M = d; PCPlus4M = pc; rdM = rd; ResultSrcM = 2'd1;
                end
                dmem_gnt = (c == g);
                #1;
                checks++;
                if ({dmem_req, StallM} !== {1'b1, (c < g)}) begin
                    failures++; $display("FAIL store_hs c=%0d: got req/stall=%b%b required 1%b", c, dmem_req, StallM, (c < g));
                end
                checks++;
                if ({dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, addr & 32'hFFFF_FFFC, m_be(f3, addr), m_wdata(f3, d)}) begin
                    failures++;
                    $display("FAIL store_lane: got we=%b addr=%h be=%b wdata=%h required we=1 addr=%h be=%b wdata=%h",
                             dmem_we, dmem_addr, dmem_be, dmem_wdata, addr & 32'hFFFF_FFFC, m_be(f3, addr), m_wdata(f3, d));
                end
            end
            @(negedge clk);
            checks++;
            if ({RegWriteW, rdW, ALUResultW, ReadDataW} !== {rw, rd, addr, 32'd0}) begin
                failures++; $display("FAIL store_w: got rw=%b rd=%0d alu=%h rdata=%h required rw=%b rd=%0d alu=%h rdata=0",
                                     RegWriteW, rdW, ALUResultW, ReadDataW, rw, rd, addr);
            end
            idle_inputs();
        end
    endtask

    task automatic test_load(input int n);
        logic [2:0]  lf [5];
        logic [2:0]  f3;
        logic [31:0] addr, rdata, exp, pc;
        logic [4:0]  rd;
        logic [1:0]  rs;
        int          g, r;
        lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < n; i++) begin
            if (i < 2) begin
                f3 = (i == 0) ? 3'd0 : 3'd4; addr = 32'h2001; rdata = 32'h0000_8000; g = 0; r = 3;
            end else begin
                f3 = lf[$urandom_range(0, 4)];
                addr = $urandom & ~32'(m_size(f3) - 1);
                rdata = $urandom; g = $urandom_range(0, 3); r = $urandom_range(1, 3);
            end
            rd = 5'($urandom); pc = $urandom; rs = 2'($urandom);
            exp = m_load(f3, addr, rdata);
            for (int c = 0; c <= g + r; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    ValidM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = f3; RegWriteM = 1'b1;
                    ALUResultM = addr; RD2M = $urandom; PCPlus4M = pc; rdM = rd; ResultSrcM = rs;
                end
                dmem_gnt    = (c == g);
                dmem_rvalid = (c == g + r);
                dmem_rdata  = (c == g + r) ? rdata : $urandom;
                #1;
                checks++;
                if ({dmem_req, StallM} !== {(c <= g), (c != g + r)}) begin
                    failures++; $display("FAIL load_hs c=%0d: got req/stall=%b%b required %b%b",
                                         c, dmem_req, StallM, (c <= g), (c != g + r));
                end
                if (c <= g) begin
                    checks++;
                    if ({dmem_we, dmem_addr} !== {1'b0, addr & 32'hFFFF_FFFC}) begin
                        failures++; $display("FAIL load_addr: got we=%b addr=%h required we=0 addr=%h",
                                             dmem_we, dmem_addr, addr & 32'hFFFF_FFFC);
                    end
                end
                if (c > 0) begin
                    checks++;
                    if (RegWriteW !== 1'b0) begin
                        failures++; $display("FAIL load_bubble c=%0d: got RegWriteW=%b required 0", c, RegWriteW);
                    end
                end
            end
            @(negedge clk);
            checks++;
            if (ReadDataW !== exp) begin
                failures++; $display("FAIL load_data f3=%0d addr=%h: got %h required %h", f3, addr, ReadDataW, exp);
            end
            checks++;
            if ({RegWriteW, rdW, ALUResultW, PCPlus4W, ResultSrcW} !== {1'b1, rd, addr, pc, rs}) begin
                failures++; $display("FAIL load_w: got rw=%b rd=%0d alu=%h pc=%h required rw=1 rd=%0d alu=%h pc=%h",
                                     RegWriteW, rdW, ALUResultW, PCPlus4W, rd, addr, pc);
            end
            idle_inputs();
        end
    endtask

    task automatic test_bad(input int n);
        logic [2:0]  f3;
        logic [31:0] addr;
        bit          rdb, wrb;
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin f3 = 3'd2; addr = 32'h3002; rdb = 1'b1; wrb = 1'b0; end
            else begin
                do begin
                    f3 = 3'($urandom); addr = $urandom; rdb = 1'($urandom); wrb = 1'($urandom);
                    if (!rdb && !wrb) rdb = 1'b1;
                end while (!m_bad(f3, rdb, wrb, addr));
            end
            @(negedge clk);
            ValidM = 1'b1; MemReadM = rdb; MemWriteM = wrb; Funct3M = f3; RegWriteM = 1'b1;
            ALUResultM = addr; RD2M = $urandom; rdM = 5'd9; PCPlus4M = 32'h40;
            dmem_gnt = 1'b1;
            #1;
            checks++;
            if ({dmem_req, MemErrM, StallM} !== 3'b010) begin
                failures++; $display("FAIL bad_ctrl f3=%0d r=%b w=%b addr=%h: got req/err/stall=%b required 010",
                                     f3, rdb, wrb, addr, {dmem_req, MemErrM, StallM});
            end
            @(negedge clk);
            checks++;
            if ({RegWriteW, ALUResultW, ReadDataW} !== {1'b0, addr, 32'd0}) begin
                failures++; $display("FAIL bad_w: got rw=%b alu=%h rdata=%h required rw=0 alu=%h rdata=0",
                                     RegWriteW, ALUResultW, ReadDataW, addr);
            end
            idle_inputs();
            #1;
            checks++;
            if (MemErrM !== 1'b0) begin
                failures++; $display("FAIL bad_pulse: got MemErrM=%b required 0", MemErrM);
            end
        end
    endtask

    task automatic test_timeout();
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c <= 4; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    ValidM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2; RegWriteM = 1'b1;
                    ALUResultM = 32'h0000_4000; rdM = 5'd3; PCPlus4M = 32'h50;
                end
                dmem_gnt = (ph == 1 && c == 0);
                dmem_rvalid = 1'b0;
                #1;
                checks++;
                if ({StallM, MemErrM, dmem_req} !== {(c < 4), (c == 4), (ph == 0 || c == 0)}) begin
                    failures++; $display("FAIL timeout ph=%0d c=%0d: got stall/err/req=%b required %b%b%b", ph, c,
                                         {StallM, MemErrM, dmem_req}, (c < 4), (c == 4), (ph == 0 || c == 0));
                end
            end
            @(negedge clk);
            checks++;
            if ({RegWriteW, ALUResultW} !== {1'b0, 32'h0000_4000}) begin
                failures++; $display("FAIL timeout_w: got rw=%b alu=%h required rw=0 alu=00004000", RegWriteW, ALUResultW);
            end
            idle_inputs();
            #1;
            checks++;
            if ({StallM, dmem_req, MemErrM} !== 3'b000) begin
                failures++; $display("FAIL timeout_idle: got stall/req/err=%b required 000", {StallM, dmem_req, MemErrM});
            end
        end
    endtask

    task automatic test_back_to_back(input int n);
        logic [31:0] p_alu, p_pc, addr, d;
        logic [4:0]  p_rd;
        logic [1:0]  p_rs;
        logic        p_rw, rw;
        logic [2:0]  f3;
        int          kind;
        p_alu = 32'd0; p_pc = 32'd0; p_rd = 5'd0; p_rs = 2'd0; p_rw = 1'b0;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if ({RegWriteW, rdW, ALUResultW, PCPlus4W, ResultSrcW, ReadDataW} !== {p_rw, p_rd, p_alu, p_pc, p_rs, 32'd0}) begin
                    failures++; $display("FAIL b2b_w i=%0d: got rw=%b rd=%0d alu=%h pc=%h required rw=%b rd=%0d alu=%h pc=%h",
                                         i, RegWriteW, rdW, ALUResultW, PCPlus4W, p_rw, p_rd, p_alu, p_pc);
                end
            end
            if (i == n) break;
            idle_inputs();
            kind = $urandom_range(0, 2);
            f3 = 3'($urandom_range(0, 2));
            addr = $urandom & ~32'(m_size(f3) - 1);
            d = $urandom; rw = 1'($urandom);
            ValidM = (kind != 2); MemWriteM = (kind == 1); MemReadM = (kind == 2) ? 1'($urandom) : 1'b0;
            Funct3M = f3; ALUResultM = addr; RD2M = d; RegWriteM = rw;
            PCPlus4M = $urandom; rdM = 5'($urandom); ResultSrcM = 2'($urandom);
            dmem_gnt = (kind == 1);
            p_rw = (kind != 2) && rw; p_rd = rdM; p_alu = addr; p_pc = PCPlus4M; p_rs = ResultSrcM;
            #1;
            checks++;
            if ({StallM, MemErrM, dmem_req} !== {2'b00, (kind == 1)}) begin
                failures++; $display("FAIL b2b_ctrl kind=%0d: got stall/err/req=%b required 00%b", kind,
                                     {StallM, MemErrM, dmem_req}, (kind == 1));
            end
            if (kind == 1) begin
                checks++;
                if ({dmem_be, dmem_wdata} !== {m_be(f3, addr), m_wdata(f3, d)}) begin
                    failures++; $display("FAIL b2b_lane: got be=%b wdata=%h required be=%b wdata=%h",
                                         dmem_be, dmem_wdata, m_be(f3, addr), m_wdata(f3, d));
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        for (int ph = 0; ph < 2; ph++) begin
            @(negedge clk);
            idle_inputs();
            ValidM = 1'b1; RegWriteM = 1'b1; rdM = 5'd7; ALUResultM = 32'hDEAD_0000 + 32'(ph); PCPlus4M = 32'h44;
            @(negedge clk);
            ValidM = 1'b1; MemReadM = 1'b1; Funct3M = 3'd0; RegWriteM = 1'b1; ALUResultM = 32'h2001;
            dmem_gnt = (ph == 0);
            @(negedge clk);
            dmem_gnt = 1'b0;
            #1;
            checks++;
            if ({StallM, dmem_req} !== {1'b1, (ph == 1)}) begin
                failures++; $display("FAIL rstmid_pre ph=%0d: got stall/req=%b%b required 1%b", ph, StallM, dmem_req, (ph == 1));
            end
            rst = 1'b1;
            #1;
            checks++;
            if ({dmem_req, StallM, MemErrM} !== 3'b000) begin
                failures++; $display("FAIL rstmid_ctrl ph=%0d: got req/stall/err=%b required 000", ph, {dmem_req, StallM, MemErrM});
            end
            checks++;
            if ({RegWriteW, ALUResultW, PCPlus4W, rdW, ReadDataW} !== 102'd0) begin
                failures++; $display("FAIL rstmid_w ph=%0d: got alu=%h pc=%h rd=%0d required zeros", ph, ALUResultW, PCPlus4W, rdW);
            end
            idle_inputs();
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
            #1;
            checks++;
            if ({StallM, dmem_req} !== 2'b00) begin
                failures++; $display("FAIL rstmid_stray ph=%0d: got stall/req=%b%b required 00", ph, StallM, dmem_req);
            end
            @(negedge clk);
            dmem_rvalid = 1'b0;
            checks++;
            if ({RegWriteW, ReadDataW} !== 33'd0) begin
                failures++; $display("FAIL rstmid_data ph=%0d: got rw=%b rdata=%h required 0 0", ph, RegWriteW, ReadDataW);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clk = 1'b0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_alu(20);
        test_store(30);
        test_load(30);
        test_bad(20);
        test_timeout();
        test_back_to_back(40);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
